// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I instruction-fetch stage with IF/ID pipeline register.
//            Owns the fetch PC, issues one outstanding valid/ready request to
//            instruction memory, applies stall/flush/redirect, and parks one
//            response in a skid buffer while decode is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_REQ_KILL  = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_WAIT_KILL = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_f_q;
  logic [31:0] addr_q;
  logic        issue;
  logic        can_issue;
  logic        live_resp;

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  // A response is only usable in WAIT and only if no redirect kills it now.
  assign live_resp = (state_q == S_WAIT) && imem_resp_valid && !pc_src_e;

  // New requests need a free skid slot after this cycle's IF/ID update.
  assign can_issue = !stall_f && !buf_valid_d && !pc_src_e;

  // IF/ID register and skid buffer next-state, in priority order.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    if (flush_d) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      buf_valid_d  = 1'b0;
    end else if (stall_d) begin
      if (live_resp) begin
        buf_valid_d = 1'b1;
        buf_instr_d = imem_rdata;
        buf_pc_d    = addr_q;
      end
    end else if (buf_valid_q) begin
      ifid_instr_d = buf_instr_q;
      ifid_pc_d    = buf_pc_q;
      ifid_pc4_d   = buf_pc_q + 32'd4;
      ifid_valid_d = 1'b1;
      buf_valid_d  = 1'b0;
    end else if (live_resp) begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = addr_q;
      ifid_pc4_d   = addr_q + 32'd4;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
    // A redirect invalidates anything parked from the old path.
    if (pc_src_e) begin
      buf_valid_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; issue marks every transition into REQ.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          state_d = S_REQ;
          issue   = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = pc_src_e ? S_WAIT_KILL : S_WAIT;
        end else if (pc_src_e) begin
          state_d = S_REQ_KILL;
        end
      end
      S_REQ_KILL: begin
        if (imem_req_ready) begin
          state_d = S_WAIT_KILL;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (pc_src_e) begin
            state_d = S_IDLE;
          end else if (can_issue) begin
            state_d = S_REQ;
            issue   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (pc_src_e) begin
          state_d = S_WAIT_KILL;
        end
      end
      S_WAIT_KILL: begin
        if (imem_resp_valid) begin
          if (can_issue) begin
            state_d = S_REQ;
            issue   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: a request is presented in both request states.
  always_comb begin
    imem_req_valid = (state_q == S_REQ) || (state_q == S_REQ_KILL);
  end

  // Fetch PC and request address; address only changes when a request issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (pc_src_e) begin
        pc_f_q <= pc_target_e;
      end else if (issue) begin
        pc_f_q <= pc_f_q + 32'd4;
      end
      if (issue) begin
        addr_q <= pc_f_q;
      end
    end
  end

  // IF/ID pipeline register and skid buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= 32'd0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign imem_addr  = addr_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Memory returns
//            0x1000_0000 + address one cycle after a request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic        resp_en;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  // One clock: memory answers the request accepted on this edge next cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = hs && resp_en;
    imem_rdata      = hs ? (32'h1000_0000 + a) : 32'hDEAD_BEEF;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
    pc_target_e = 32'h0; imem_req_ready = 1; imem_resp_valid = 0;
    imem_rdata = 32'h0; resp_en = 1;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0h exp 0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %08h exp 00000000", imem_addr); end
    checks++; if (instr_d !== 32'h13) begin errors++; $display("FAIL rst_instr got %08h exp 00000013", instr_d); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL rst_pc got %08h exp 00000000", pc_d); end
    checks++; if (pc_plus4_d !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %08h exp 00000000", pc_plus4_d); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", valid_d); end
  endtask

  task automatic test_sequential();
    do_reset();
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_req0 got v=%0h a=%08h exp v=1 a=00000000", imem_req_valid, imem_addr); end
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== 32'h1000_0000 || pc_plus4_d !== 32'h4) begin errors++; $display("FAIL seq_d0 got v=%0h pc=%08h i=%08h p4=%08h exp v=1 pc=0 i=10000000 p4=4", valid_d, pc_d, instr_d, pc_plus4_d); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4 got %08h exp 00000004", imem_addr); end
    tick();
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL seq_bubble got %0h exp 0", valid_d); end
    tick();
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h4 || instr_d !== 32'h1000_0004 || pc_plus4_d !== 32'h8) begin errors++; $display("FAIL seq_d4 got v=%0h pc=%08h i=%08h p4=%08h exp v=1 pc=4 i=10000004 p4=8", valid_d, pc_d, instr_d, pc_plus4_d); end
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h8 || instr_d !== 32'h1000_0008 || pc_plus4_d !== 32'hC) begin errors++; $display("FAIL seq_d8 got v=%0h pc=%08h i=%08h p4=%08h exp v=1 pc=8 i=10000008 p4=c", valid_d, pc_d, instr_d, pc_plus4_d); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ticks(3);
    imem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      stall_f = (i == 1);
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL bp_hold%0d got v=%0h a=%08h exp v=1 a=00000004", i, imem_req_valid, imem_addr); end
    end
    stall_f = 0;
    imem_req_ready = 1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %0h exp 0", imem_req_valid); end
    tick();
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h4 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_deliver got v=%0h pc=%08h a=%08h exp v=1 pc=4 a=8", valid_d, pc_d, imem_addr); end
  endtask

  task automatic test_stall_d();
    do_reset();
    ticks(6);
    stall_d = 1;
    tick();
    checks++; if (imem_req_valid !== 1'b0 || valid_d !== 1'b0 || pc_d !== 32'h4) begin errors++; $display("FAIL sd_hold got rv=%0h v=%0h pc=%08h exp rv=0 v=0 pc=4", imem_req_valid, valid_d, pc_d); end
    checks++; if (dut.buf_valid_q !== 1'b1) begin errors++; $display("FAIL sd_buf got %0h exp 1", dut.buf_valid_q); end
    tick();
    checks++; if (imem_req_valid !== 1'b0 || pc_d !== 32'h4) begin errors++; $display("FAIL sd_hold2 got rv=%0h pc=%08h exp rv=0 pc=4", imem_req_valid, pc_d); end
    stall_d = 0;
    tick();
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h8 || instr_d !== 32'h1000_0008 || pc_plus4_d !== 32'hC) begin errors++; $display("FAIL sd_drain got v=%0h pc=%08h i=%08h p4=%08h exp v=1 pc=8 i=10000008 p4=c", valid_d, pc_d, instr_d, pc_plus4_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC || dut.buf_valid_q !== 1'b0) begin errors++; $display("FAIL sd_next got v=%0h a=%08h b=%0h exp v=1 a=c b=0", imem_req_valid, imem_addr, dut.buf_valid_q); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ticks(9);
    resp_en = 0;
    tick();
    pc_src_e = 1; pc_target_e = 32'h100; flush_d = 1;
    tick();
    checks++; if (valid_d !== 1'b0 || imem_req_valid !== 1'b0 || instr_d !== 32'h13) begin errors++; $display("FAIL rw_kill got v=%0h rv=%0h i=%08h exp v=0 rv=0 i=13", valid_d, imem_req_valid, instr_d); end
    pc_src_e = 0; flush_d = 0; resp_en = 1;
    imem_resp_valid = 1; imem_rdata = 32'h1000_0010;
    tick();
    checks++; if (valid_d !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_discard got v=%0h rv=%0h a=%08h exp v=0 rv=1 a=100", valid_d, imem_req_valid, imem_addr); end
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h100 || instr_d !== 32'h1000_0100 || pc_plus4_d !== 32'h104) begin errors++; $display("FAIL rw_target got v=%0h pc=%08h i=%08h p4=%08h exp v=1 pc=100 i=10000100 p4=104", valid_d, pc_d, instr_d, pc_plus4_d); end
  endtask

  task automatic test_req_kill();
    do_reset();
    tick();
    imem_req_ready = 0; pc_src_e = 1; pc_target_e = 32'h200; flush_d = 1;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rk_hold got v=%0h a=%08h exp v=1 a=0", imem_req_valid, imem_addr); end
    pc_src_e = 0; flush_d = 0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rk_hold2 got v=%0h a=%08h exp v=1 a=0", imem_req_valid, imem_addr); end
    imem_req_ready = 1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rk_accept got %0h exp 0", imem_req_valid); end
    tick();
    checks++; if (valid_d !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rk_discard got v=%0h rv=%0h a=%08h exp v=0 rv=1 a=200", valid_d, imem_req_valid, imem_addr); end
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || instr_d !== 32'h1000_0200) begin errors++; $display("FAIL rk_target got v=%0h pc=%08h i=%08h exp v=1 pc=200 i=10000200", valid_d, pc_d, instr_d); end
    stall_d = 1;
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || dut.buf_valid_q !== 1'b1) begin errors++; $display("FAIL rk_stall got v=%0h pc=%08h b=%0h exp v=1 pc=200 b=1", valid_d, pc_d, dut.buf_valid_q); end
    flush_d = 1;
    tick();
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h13 || pc_plus4_d !== 32'h204 || dut.buf_valid_q !== 1'b0) begin errors++; $display("FAIL rk_flush got v=%0h i=%08h p4=%08h b=%0h exp v=0 i=13 p4=204 b=0", valid_d, instr_d, pc_plus4_d, dut.buf_valid_q); end
    flush_d = 0; stall_d = 0;
  endtask

  task automatic test_reset_wait_kill();
    do_reset();
    tick();
    resp_en = 0;
    tick();
    pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC; flush_d = 1;
    tick();
    pc_src_e = 0; flush_d = 0;
    rst_n = 0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h13) begin errors++; $display("FAIL rwk_rst got rv=%0h a=%08h v=%0h i=%08h exp rv=0 a=0 v=0 i=13", imem_req_valid, imem_addr, valid_d, instr_d); end
    imem_resp_valid = 1; imem_rdata = 32'hBAD0_0000;
    rst_n = 1; resp_en = 1;
    tick();
    checks++; if (valid_d !== 1'b0 || pc_d !== 32'h0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rwk_late got v=%0h pc=%08h rv=%0h a=%08h exp v=0 pc=0 rv=1 a=0", valid_d, pc_d, imem_req_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC; flush_d = 1;
    tick();
    pc_src_e = 0; flush_d = 0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || valid_d !== 1'b0) begin errors++; $display("FAIL wrap_req got rv=%0h a=%08h v=%0h exp rv=1 a=fffffffc v=0", imem_req_valid, imem_addr, valid_d); end
    ticks(2);
    checks++; if (valid_d !== 1'b1 || pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0 || instr_d !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_d got v=%0h pc=%08h p4=%08h i=%08h exp v=1 pc=fffffffc p4=0 i=0ffffffc", valid_d, pc_d, pc_plus4_d, instr_d); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %08h exp 00000000", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_stall_d();
    test_redirect_wait();
    test_req_kill();
    test_reset_wait_kill();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline, directly upstream of decode.
- Owns the fetch PC and a one-outstanding valid/ready request port to instruction memory.
- Applies the hazard unit's stall_f, stall_d and flush_d, and the execute-stage redirect (pc_src_e, pc_target_e).
- Presents instr_d/pc_d/pc_plus4_d/valid_d to decode.
- Holds one response in a skid buffer while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_f  input  1  hold PC, issue no new request
stall_d  input  1  hold IF/ID register
flush_d  input  1  load bubble into IF/ID
pc_src_e  input  1  taken branch/jump redirect from execute
pc_target_e  input  32  redirect target
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  request address, stable while valid
imem_resp_valid  input  1  response data valid (no backpressure)
imem_rdata  input  32  response instruction
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
pc_plus4_d  output  32  pc_d + 4
valid_d  output  1  IF/ID holds a real instruction

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, pc_f=RESET_PC, imem_addr=RESET_PC.
- imem_req_valid=0, buf_valid=0.
- instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
- Reset mid-transaction drops all in-flight state. Any imem_resp_valid arriving while in IDLE/REQ/REQ_KILL is ignored.

Definitions:
- can_issue = !stall_f && !buf_valid_next && !pc_src_e.

States (imem_req_valid=1 exactly in REQ, REQ_KILL; registered):
- IDLE: if can_issue -> REQ; on entry imem_addr<=pc_f, pc_f<=pc_f+4.
- REQ: ready=1 -> WAIT, or WAIT_KILL if pc_src_e the same cycle. ready=0 and pc_src_e -> REQ_KILL.
- REQ_KILL: keep valid/addr stable; ready=1 -> WAIT_KILL.
- WAIT: resp_valid -> deliver/buffer the response (pc = imem_addr), then REQ (with the same entry actions) if can_issue, else IDLE. pc_src_e without resp -> WAIT_KILL. pc_src_e with resp -> discard the response, go IDLE.
- WAIT_KILL: resp_valid -> discard, then REQ if can_issue, else IDLE.

PC rules:
- pc_src_e=1: pc_f<=pc_target_e, overriding increment and stall_f.
- stall_f holds pc_f.
- Arithmetic is 32-bit wrap (0xFFFF_FFFC+4=0).

Request stability:
- Once imem_req_valid=1, it and imem_addr do not change until accepted.
- stall_f and pc_src_e never withdraw a presented request.

IF/ID update, evaluated each cycle in priority order:
1. flush_d=1: bubble (instr_d=NOP_INSTR, valid_d=0); buf_valid<=0. Wins over stall_d.
2. stall_d=1: hold. An accepted live response goes to the skid buffer (buf_valid<=1).
3. buf_valid=1: load from buffer, buf_valid<=0.
4. Live response: load instr_d=imem_rdata, pc_d=imem_addr, valid_d=1.
5. Otherwise: bubble.

Additional rules:
- pc_src_e=1 also clears buf_valid; hazard asserts flush_d with it.
- pc_plus4_d always equals pc_d+4 for a real instruction; on a bubble it keeps its old value.
- The skid buffer holds at most one entry. No issue while it is full, so no overflow is possible.
- Throughput with zero-wait memory (ready=1, resp next cycle): one instruction per 2 cycles. This is a documented property, not a bug.

Test Plan:
- Reset release, memory always ready, 1-cycle response: addresses 0x0,0x4,0x8 issued -> valid_d=1 with pc_d=0x0,0x4,0x8 and instr_d matching rdata; pc_plus4_d=pc_d+4.
- imem_req_ready low for 3 cycles at addr 0x4, stall_f pulsed meanwhile -> imem_req_valid stays 1 and imem_addr stays 0x4 until acceptance.
- stall_d=1 while the response for 0x8 arrives -> IF/ID unchanged, buf_valid=1, no new request. stall_d drops -> pc_d=0x8 next cycle, then request 0xC issued.
- pc_src_e=1, target 0x100, in WAIT for 0x10 -> response for 0x10 discarded (valid_d=0). Next request address 0x100, delivered with pc_d=0x100.
- pc_src_e in REQ with ready=0 -> REQ_KILL; request held until accepted, its response discarded, then fetch from target. Also: flush_d and stall_d together -> bubble, buffer cleared.
- rst_n asserted in WAIT_KILL, then a late resp_valid -> all outputs at reset values, response ignored. Also: pc_target_e=0xFFFF_FFFC -> next fetch is 0x0.
